// File: rtl/counter_data_path.sv
// counter_data_path: step/result registers, y_inc flag and 4-digit multiplexed 7-segment display driver
module counter_data_path #(
    parameter int S_W      = 4,
    parameter int Y_W      = 8,
    parameter int S_MOD    = 3,
    parameter int SCAN_DIV = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [Y_W-1:0] x,
    input  logic           s_en,
    input  logic           s_zero,
    input  logic           s_add,
    input  logic [1:0]     s_step,
    input  logic           y_en,
    input  logic           y_store_x,
    input  logic [1:0]     y_select_next,
    input  logic [1:0]     regime,
    input  logic           active,
    output logic           y_inc,
    output logic [S_W-1:0] s,
    output logic [Y_W-1:0] y,
    output logic [3:0]     an,
    output logic [6:0]     seg,
    output logic           dp
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    logic [S_W-1:0] s_q, s_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     an_q, an_d, nib;
    logic [6:0]     seg_q, seg_d;
    logic           dp_q, dp_d, tc;
    logic [S_W:0]   step_w, sum, s_w, mod_w;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        step_w = (S_W+1)'(s_step);
        s_w    = {1'b0, s_q};
        mod_w  = (S_W+1)'(S_MOD);
        sum    = s_w + step_w;
        // add wraps with a single subtraction of S_MOD; subtract saturates at zero
        s_d = !s_en ? s_q
            : s_zero ? S_W'(step_w + (step_w << 1))
            : s_add ? (sum >= mod_w ? S_W'(sum - mod_w) : S_W'(sum))
            : (s_w < step_w ? '0 : S_W'(s_w - step_w));
        y_d = !y_en ? y_q
            : y_store_x ? x
            : y_select_next == 2'd0 ? y_q
            : y_select_next == 2'd1 ? y_q + Y_W'(1)
            : y_select_next == 2'd2 ? y_q + Y_W'(s_q)
            : '0;
        tc    = cnt_q == CW'(SCAN_DIV - 1);
        cnt_d = tc ? '0 : cnt_q + CW'(1);
        idx_d = tc ? idx_q + 2'd1 : idx_q;
        nib   = idx_d == 2'd0 ? 4'(s_q)
              : idx_d == 2'd1 ? y_q[3:0]
              : idx_d == 2'd2 ? y_q[7:4]
              : {2'b00, regime};
        an_d  = ~(4'b0001 << idx_d);
        seg_d = (regime == 2'd0 && idx_d != 2'd3) ? 7'h7F : hex7(nib);
        dp_d  = !(idx_d == 2'd3 && active);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 4'b1110;
            seg_q <= 7'h40;
            dp_q  <= 1'b1;
        end else begin
            s_q   <= s_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign y_inc = s_q == S_W'(S_MOD - 1);
    assign s     = s_q;
    assign y     = y_q;
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
endmodule

// File: tb/tb_counter_data_path.sv
// tb_counter_data_path: scoreboard bench for counter_data_path with a 4-cycle scan slot
module tb_counter_data_path;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] x = '0;
    logic       s_en = 0, s_zero = 0, s_add = 0, y_en = 0, y_store_x = 0, active = 0;
    logic [1:0] s_step = '0, y_select_next = '0, regime = '0;
    logic       y_inc, dp;
    logic [3:0] s, an;
    logic [7:0] y;
    logic [6:0] seg;
    int checks = 0, failures = 0;
    logic [3:0]  exp_s[$];
    logic [7:0]  exp_y[$];
    logic        exp_inc[$];
    logic [11:0] exp_disp[$];

    counter_data_path #(.S_W(4), .Y_W(8), .S_MOD(3), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .x(x), .s_en(s_en), .s_zero(s_zero), .s_add(s_add),
        .s_step(s_step), .y_en(y_en), .y_store_x(y_store_x), .y_select_next(y_select_next),
        .regime(regime), .active(active), .y_inc(y_inc), .s(s), .y(y), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks += 6;
        if (s !== 4'd0)       begin failures++; $display("FAIL reset_s got %h exp 0", s); end
        if (y !== 8'd0)       begin failures++; $display("FAIL reset_y got %h exp 00", y); end
        if (y_inc !== 1'b0)   begin failures++; $display("FAIL reset_yinc got %b exp 0", y_inc); end
        if (an !== 4'b1110)   begin failures++; $display("FAIL reset_an got %b exp 1110", an); end
        if (dp !== 1'b1)      begin failures++; $display("FAIL reset_dp got %b exp 1", dp); end
        if (seg !== 7'h40)    begin failures++; $display("FAIL reset_seg got %h exp 40", seg); end
        rst = 1'b0;
    endtask

    task automatic test_s_sub();
        localparam logic [3:0] E[5] = '{6, 4, 2, 0, 0};
        logic [3:0] e;
        for (int i = 0; i < 5; i++) exp_s.push_back(E[i]);
        s_en = 1; y_en = 0; s_add = 0; s_step = 2;
        for (int i = 0; i < 5; i++) begin
            s_zero = (i == 0);
            tick();
            e = exp_s.pop_front();
            checks++;
            if (s !== e) begin failures++; $display("FAIL s_sub[%0d] got %0d exp %0d", i, s, e); end
        end
    endtask

    task automatic test_s_add();
        localparam logic [3:0] E[6]  = '{1, 2, 0, 1, 1, 1};
        localparam logic       I[6]  = '{0, 1, 0, 0, 0, 0};
        localparam logic [1:0] ST[6] = '{1, 1, 1, 1, 0, 0};
        localparam logic       AD[6] = '{1, 1, 1, 1, 1, 0};
        logic [3:0] e;
        logic       ei;
        for (int i = 0; i < 6; i++) begin exp_s.push_back(E[i]); exp_inc.push_back(I[i]); end
        s_en = 1; s_zero = 0; y_en = 0;
        for (int i = 0; i < 6; i++) begin
            s_step = ST[i]; s_add = AD[i];
            tick();
            e = exp_s.pop_front(); ei = exp_inc.pop_front();
            checks += 2;
            if (s !== e)      begin failures++; $display("FAIL s_add[%0d] got %0d exp %0d", i, s, e); end
            if (y_inc !== ei) begin failures++; $display("FAIL y_inc[%0d] got %b exp %b", i, y_inc, ei); end
        end
        checks++;
        if (y !== 8'd0) begin failures++; $display("FAIL y_hold got %h exp 00", y); end
    endtask

    task automatic test_s_wrap();
        localparam logic [3:0] E[6]  = '{6, 4, 1, 0, 9, 9};
        localparam logic       Z[6]  = '{1, 0, 0, 0, 1, 0};
        localparam logic       AD[6] = '{0, 1, 0, 0, 0, 1};
        localparam logic [1:0] ST[6] = '{2, 1, 3, 3, 3, 3};
        logic [3:0] e;
        for (int i = 0; i < 6; i++) exp_s.push_back(E[i]);
        s_en = 1; y_en = 0;
        for (int i = 0; i < 6; i++) begin
            s_zero = Z[i]; s_add = AD[i]; s_step = ST[i];
            tick();
            e = exp_s.pop_front();
            checks++;
            if (s !== e) begin failures++; $display("FAIL s_wrap[%0d] got %0d exp %0d", i, s, e); end
        end
    endtask

    task automatic test_y();
        localparam logic [7:0] E[7]  = '{8'hA5, 8'hA6, 8'h00, 8'hFF, 8'h00, 8'h09, 8'h09};
        localparam logic       SX[7] = '{1, 0, 0, 1, 0, 0, 0};
        localparam logic [7:0] X[7]  = '{8'hA5, 0, 0, 8'hFF, 0, 0, 0};
        localparam logic [1:0] SL[7] = '{3, 1, 3, 1, 1, 2, 1};
        localparam logic       EN[7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [7:0] e;
        for (int i = 0; i < 7; i++) exp_y.push_back(E[i]);
        s_en = 0;
        for (int i = 0; i < 7; i++) begin
            y_store_x = SX[i]; x = X[i]; y_select_next = SL[i]; y_en = EN[i];
            tick();
            e = exp_y.pop_front();
            checks++;
            if (y !== e) begin failures++; $display("FAIL y_path[%0d] got %h exp %h", i, y, e); end
        end
    endtask

    task automatic test_back_to_back();
        localparam logic [3:0] ES[3] = '{0, 2, 0};
        localparam logic [7:0] EY[3] = '{10, 10, 12};
        logic [3:0] es;
        logic [7:0] ey;
        for (int i = 0; i < 3; i++) begin exp_s.push_back(ES[i]); exp_y.push_back(EY[i]); end
        s_en = 1; s_zero = 1; s_step = 0; y_en = 1; y_store_x = 1; x = 8'd10;
        tick();
        es = exp_s.pop_front(); ey = exp_y.pop_front();
        checks += 2;
        if (s !== es) begin failures++; $display("FAIL b2b_s0 got %0d exp %0d", s, es); end
        if (y !== ey) begin failures++; $display("FAIL b2b_y0 got %0d exp %0d", y, ey); end
        s_zero = 0; s_add = 1; s_step = 2; y_en = 0;
        tick();
        es = exp_s.pop_front(); ey = exp_y.pop_front();
        checks += 2;
        if (s !== es) begin failures++; $display("FAIL b2b_s1 got %0d exp %0d", s, es); end
        if (y !== ey) begin failures++; $display("FAIL b2b_y1 got %0d exp %0d", y, ey); end
        s_step = 1; y_en = 1; y_store_x = 0; y_select_next = 2;
        tick();
        es = exp_s.pop_front(); ey = exp_y.pop_front();
        checks += 2;
        if (s !== es) begin failures++; $display("FAIL b2b_s2 got %0d exp %0d", s, es); end
        if (y !== ey) begin failures++; $display("FAIL b2b_y2 got %0d exp %0d", y, ey); end
        s_en = 0; y_en = 0;
    endtask

    task automatic sync_digit0(output bit ok);
        bit left = 0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (an !== 4'b1110) left = 1;
            else if (left) ok = 1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL scan_sync got an=%b exp 1110 within 40 clks", an);
        end
    endtask

    task automatic check_scan(input string tag);
        logic [11:0] e;
        for (int d = 0; d < 4; d++) begin
            e = exp_disp.pop_front();
            for (int k = 0; k < 4; k++) begin
                checks += 3;
                if (an !== e[11:8]) begin failures++; $display("FAIL %s_an[%0d.%0d] got %b exp %b", tag, d, k, an, e[11:8]); end
                if (seg !== e[7:1]) begin failures++; $display("FAIL %s_seg[%0d.%0d] got %h exp %h", tag, d, k, seg, e[7:1]); end
                if (dp !== e[0])    begin failures++; $display("FAIL %s_dp[%0d.%0d] got %b exp %b", tag, d, k, dp, e[0]); end
                tick();
            end
        end
    endtask

    task automatic test_scan_active();
        bit ok;
        s_en = 1; s_zero = 1; s_step = 0; y_en = 1; y_store_x = 1; x = 8'h3C;
        tick();
        s_zero = 0; s_add = 1; s_step = 2; y_en = 0;
        tick();
        s_en = 0; regime = 2; active = 1;
        exp_disp.push_back({4'b1110, 7'h24, 1'b1});
        exp_disp.push_back({4'b1101, 7'h46, 1'b1});
        exp_disp.push_back({4'b1011, 7'h30, 1'b1});
        exp_disp.push_back({4'b0111, 7'h24, 1'b0});
        sync_digit0(ok);
        if (ok) check_scan("scan_act");
        else exp_disp.delete();
    endtask

    task automatic test_scan_blank_reset();
        bit ok;
        regime = 0; active = 0;
        exp_disp.push_back({4'b1110, 7'h7F, 1'b1});
        exp_disp.push_back({4'b1101, 7'h7F, 1'b1});
        exp_disp.push_back({4'b1011, 7'h7F, 1'b1});
        exp_disp.push_back({4'b0111, 7'h40, 1'b1});
        sync_digit0(ok);
        if (ok) check_scan("scan_off");
        else exp_disp.delete();
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        checks += 3;
        if (an !== 4'b1110) begin failures++; $display("FAIL async_rst_an got %b exp 1110", an); end
        if (s !== 4'd0)     begin failures++; $display("FAIL async_rst_s got %0d exp 0", s); end
        if (y !== 8'd0)     begin failures++; $display("FAIL async_rst_y got %h exp 00", y); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_s_sub();
        test_s_add();
        test_s_wrap();
        test_y();
        test_back_to_back();
        test_scan_active();
        test_scan_blank_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
